// File: rtl/ad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ad_pkg
//  Purpose  : Shared constants and FSM encoding for the AD7276-class reader
//  Revision : 1.0  initial release
// ============================================================================
package ad_pkg;

    // One conversion frame: 2 leading zeros, 12 data bits, 2 trailing zeros
    localparam int AD_FRAME_BITS = 16;
    localparam int AD_DATA_W     = 12;
    localparam int AD_LEAD_ZEROS = 2;

    // Bit counter has to reach AD_FRAME_BITS itself, hence the +1
    localparam int AD_BIT_CNT_W  = $clog2(AD_FRAME_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_QUIET = 2'd3
    } ad_state_t;

endpackage : ad_pkg
`default_nettype wire

// File: rtl/ad_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ad_sclk_gen
//  Purpose  : SCLK generator for one 16-bit ADC frame. A CLK_DIV phase
//             counter toggles sclk; rise/fall are one-cycle ticks that mark
//             the clk_sys edge driving sclk 0->1 / ending a high phase.
//             sclk is forced low by start and parks high when not running.
//  Revision : 1.0  initial release
// ============================================================================
module ad_sclk_gen
    import ad_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic start,   // edge that enters the shift phase: drive sclk low
    input  logic run,     // FSM currently in the shift phase
    output logic sclk,
    output logic rise,    // this edge drives sclk 0->1 (sample point)
    output logic fall,    // this edge ends a high phase
    output logic last     // all AD_FRAME_BITS rising edges already issued
);

    localparam int                      DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [AD_BIT_CNT_W-1:0] BITS_ALL = AD_BIT_CNT_W'(AD_FRAME_BITS);

    logic [DIV_W-1:0]        div_cnt;
    logic [AD_BIT_CNT_W-1:0] bit_cnt;
    logic                    wrap;

    assign wrap = run && (div_cnt == DIV_LAST);
    assign rise = wrap && !sclk;
    assign fall = wrap &&  sclk;
    assign last = (bit_cnt == BITS_ALL);

    // Half-period counter, sclk toggle and rising-edge count; after the final
    // high phase sclk is left high so the frame ends with sclk idle.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sclk    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (start) begin
            sclk    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (!run) begin
            sclk    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (wrap) begin
            div_cnt <= '0;
            if (!sclk) begin
                sclk    <= 1'b1;
                bit_cnt <= bit_cnt + AD_BIT_CNT_W'(1);
            end else if (!last) begin
                sclk    <= 1'b0;
            end
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule : ad_sclk_gen
`default_nettype wire

// File: rtl/ad_rd.sv
`default_nettype none
// ============================================================================
//  Module   : ad_rd
//  Purpose  : Serial reader for one AD7276-class 12-bit ADC channel. Paces
//             conversions from SAMPLE_PERIOD, runs one 16-clock frame per
//             trigger, strobes ad_vld with the captured sample and counts
//             triggers that arrive while a frame is still busy.
//  Config   : AD_TEST_PATTERN_EN - ad_data carries a per-frame ramp
//             (0,1,2,...) instead of the shifted sdata value.
//  Revision : 1.0  initial release
// ============================================================================
module ad_rd
    import ad_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 200,
    parameter int QUIET         = 8
) (
    input  logic                 clk_sys,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 sdata,
    output logic                 cs_n,
    output logic                 sclk,
    output logic [AD_DATA_W-1:0] ad_data,
    output logic                 ad_vld,
    output logic                 ad_busy,
    output logic [7:0]           ad_miss
);

    localparam int                TRIG_W     = $clog2(SAMPLE_PERIOD + 1);
    localparam int                PH_MAX     = (CLK_DIV > QUIET) ? CLK_DIV : QUIET;
    localparam int                PH_W       = $clog2(PH_MAX + 1);
    localparam logic [TRIG_W-1:0] TRIG_LAST  = TRIG_W'(SAMPLE_PERIOD - 1);
    localparam logic [PH_W-1:0]   SETUP_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]   QUIET_LAST = PH_W'(QUIET - 1);
    // MSB of the data field inside the frame shift register
    localparam int                DATA_MSB   = AD_FRAME_BITS - AD_LEAD_ZEROS - 1;

    ad_state_t                state;
    ad_state_t                state_nxt;
    logic [TRIG_W-1:0]        trig_cnt;
    logic                     trig;
    logic [PH_W-1:0]          ph_cnt;
    logic [AD_FRAME_BITS-1:0] shift_reg;
    logic [AD_DATA_W-1:0]     sample_word;
    logic                     sclk_rise;
    logic                     sclk_fall;
    logic                     sclk_last;
    logic                     frame_done;
    logic                     cs_n_nxt;
    logic                     busy_nxt;
    logic                     shift_start;
    logic                     shift_run;
    logic                     miss_hit;

    assign trig       = enable && (trig_cnt == TRIG_LAST);
    assign frame_done = sclk_fall && sclk_last;

    // Sample-period counter: held at 0 while disabled, wraps with a trigger
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            trig_cnt <= '0;
        end else if (!enable || trig) begin
            trig_cnt <= '0;
        end else begin
            trig_cnt <= trig_cnt + TRIG_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; a trigger outside S_IDLE never alters the frame
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (trig)                 state_nxt = S_SETUP;
            S_SETUP: if (ph_cnt == SETUP_LAST) state_nxt = S_SHIFT;
            S_SHIFT: if (frame_done)           state_nxt = S_QUIET;
            S_QUIET: if (ph_cnt == QUIET_LAST) state_nxt = S_IDLE;
            default:                           state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs; pin-level values are computed from the next state so the
    // pins themselves can be plain flops
    always_comb begin
        cs_n_nxt    = !((state_nxt == S_SETUP) || (state_nxt == S_SHIFT));
        busy_nxt    = (state_nxt != S_IDLE);
        shift_start = (state == S_SETUP) && (state_nxt == S_SHIFT);
        shift_run   = (state == S_SHIFT);
        miss_hit    = trig && (state != S_IDLE);
    end

    // Cycle counter for the setup and quiet phases, cleared on state change
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            ph_cnt <= '0;
        end else if (state_nxt != state) begin
            ph_cnt <= '0;
        end else if ((state == S_SETUP) || (state == S_QUIET)) begin
            ph_cnt <= ph_cnt + PH_W'(1);
        end else begin
            ph_cnt <= '0;
        end
    end

    ad_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .start   (shift_start),
        .run     (shift_run),
        .sclk    (sclk),
        .rise    (sclk_rise),
        .fall    (sclk_fall),
        .last    (sclk_last)
    );

    // Frame shift register, MSB first, loaded on each sclk rising edge
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
        end else if (sclk_rise) begin
            shift_reg <= {shift_reg[AD_FRAME_BITS-2:0], sdata};
        end
    end

`ifdef AD_TEST_PATTERN_EN
    logic [AD_DATA_W-1:0] pattern;
    logic                 unused_frame_bits;

    // Ramp source: advances once per completed frame, wraps naturally
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            pattern <= '0;
        end else if (frame_done) begin
            pattern <= pattern + AD_DATA_W'(1);
        end
    end

    assign sample_word       = pattern;
    // The serial capture still runs so pin timing is identical; its content
    // is simply not used in this build.
    assign unused_frame_bits = ^shift_reg;
`else
    logic unused_frame_bits;

    assign sample_word       = shift_reg[DATA_MSB -: AD_DATA_W];
    // Leading and trailing zero bits are dropped without being checked
    assign unused_frame_bits = ^{shift_reg[AD_FRAME_BITS-1 -: AD_LEAD_ZEROS],
                                 shift_reg[AD_LEAD_ZEROS-1:0]};
`endif

    // Sample capture and valid strobe, coincident with cs_n returning high
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            ad_data <= '0;
            ad_vld  <= 1'b0;
        end else begin
            ad_vld <= frame_done;
            if (frame_done) begin
                ad_data <= sample_word;
            end
        end
    end

    // Registered chip select and busy flag
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cs_n    <= 1'b1;
            ad_busy <= 1'b0;
        end else begin
            cs_n    <= cs_n_nxt;
            ad_busy <= busy_nxt;
        end
    end

    // Saturating count of triggers dropped because a frame was in progress
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            ad_miss <= '0;
        end else if (miss_hit && (ad_miss != 8'hFF)) begin
            ad_miss <= ad_miss + 8'd1;
        end
    end

endmodule : ad_rd
`default_nettype wire

// File: tb/tb_ad_rd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ad_rd
//  Purpose  : Directed self-checking bench for ad_rd. A default instance is
//             driven by a behavioural ADC model; a second instance with a
//             100-cycle sample period exercises missed triggers.
//  Config   : AD_TEST_PATTERN_EN switches expected ad_data to the ramp.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ad_rd;

`ifdef AD_TEST_PATTERN_EN
    localparam bit PATTERN = 1'b1;
`else
    localparam bit PATTERN = 1'b0;
`endif

    logic        clk_sys  = 1'b0;
    logic        rst_n    = 1'b0;
    logic        enable   = 1'b0;
    logic        sdata    = 1'b0;
    logic        enable_f = 1'b0;
    logic        sdata_f  = 1'b1;

    logic        cs_n, sclk, ad_vld, ad_busy;
    logic [11:0] ad_data;
    logic [7:0]  ad_miss;
    logic        cs_n_f, sclk_f, ad_vld_f, ad_busy_f;
    logic [11:0] ad_data_f;
    logic [7:0]  ad_miss_f;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pat_idx = 0;

    ad_rd #(.CLK_DIV(4), .SAMPLE_PERIOD(200), .QUIET(8)) dut (
        .clk_sys (clk_sys), .rst_n (rst_n), .enable (enable), .sdata (sdata),
        .cs_n (cs_n), .sclk (sclk), .ad_data (ad_data), .ad_vld (ad_vld),
        .ad_busy (ad_busy), .ad_miss (ad_miss)
    );

    ad_rd #(.CLK_DIV(4), .SAMPLE_PERIOD(100), .QUIET(8)) dut_fast (
        .clk_sys (clk_sys), .rst_n (rst_n), .enable (enable_f), .sdata (sdata_f),
        .cs_n (cs_n_f), .sclk (sclk_f), .ad_data (ad_data_f), .ad_vld (ad_vld_f),
        .ad_busy (ad_busy_f), .ad_miss (ad_miss_f)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // ADC model: one queued 12-bit value per frame, framed as 00_data_11.
    // The trailing ones are junk the reader must ignore. Bits update on
    // sclk falling edges so each rising edge samples a settled bit.
    logic [11:0] adc_q[$];
    logic [15:0] adc_word = 16'h0000;
    int          bit_idx  = 15;

    always @(negedge cs_n) begin
        if (adc_q.size() > 0) adc_word = {2'b00, adc_q.pop_front(), 2'b11};
        bit_idx = 15;
        sdata   = adc_word[15];
    end

    always @(negedge sclk) begin
        if (!cs_n) begin
            sdata = adc_word[bit_idx];
            if (bit_idx > 0) bit_idx--;
        end
    end

    // Event monitor for the main instance, sampled on the inactive edge
    logic        cs_prev = 1'b1, sclk_prev = 1'b1, busy_prev = 1'b0;
    int          fall_cnt = 0, fall_cyc = 0, low_len = 0, sclk_rises = 0;
    int          vld_cnt = 0, busy_cyc = 0, busy_len = 0;
    int          vld_cyc_q[$];
    logic [11:0] vld_dat_q[$];

    always @(negedge clk_sys) begin
        if (cs_prev && !cs_n) begin
            fall_cnt++;
            fall_cyc   = cyc;
            sclk_rises = 0;
        end
        if (!cs_prev && cs_n) low_len = cyc - fall_cyc;
        if (!cs_n && !sclk_prev && sclk) sclk_rises++;
        if (!busy_prev && ad_busy) busy_cyc = cyc;
        if (busy_prev && !ad_busy) busy_len = cyc - busy_cyc;
        if (ad_vld) begin
            vld_cnt++;
            vld_cyc_q.push_back(cyc);
            vld_dat_q.push_back(ad_data);
        end
        cs_prev   = cs_n;
        sclk_prev = sclk;
        busy_prev = ad_busy;
    end

    // Monitor for the short-period instance: frame count and frame lengths
    logic f_cs_prev = 1'b1;
    int   f_fall_cyc = 0, f_frames = 0, f_bad_frames = 0, f_vld_cnt = 0;

    always @(negedge clk_sys) begin
        if (f_cs_prev && !cs_n_f) f_fall_cyc = cyc;
        if (!f_cs_prev && cs_n_f && rst_n) begin
            f_frames++;
            if (cyc - f_fall_cyc != 132) f_bad_frames++;
        end
        if (ad_vld_f) f_vld_cnt++;
        f_cs_prev = cs_n_f;
    end

    function automatic logic [11:0] exp_data(input logic [11:0] adc_val, input int idx);
        return PATTERN ? 12'(idx) : adc_val;
    endfunction

    task automatic wait_vld_cnt(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_sys); #1;
            if (vld_cnt >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_fall_cnt(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_sys); #1;
            if (fall_cnt >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b0; enable_f = 1'b0;
        repeat (3) @(negedge clk_sys);
        #1;
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
        checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b expected 1", sclk); end
        checks++; if (ad_data !== 12'h000) begin errors++; $display("FAIL reset_ad_data: got %h expected 000", ad_data); end
        checks++; if (ad_vld !== 1'b0) begin errors++; $display("FAIL reset_ad_vld: got %b expected 0", ad_vld); end
        checks++; if (ad_busy !== 1'b0) begin errors++; $display("FAIL reset_ad_busy: got %b expected 0", ad_busy); end
        checks++; if (ad_miss !== 8'h00) begin errors++; $display("FAIL reset_ad_miss: got %0d expected 0", ad_miss); end
        rst_n = 1'b1;
        repeat (300) @(negedge clk_sys);
        #1;
        checks++; if (fall_cnt !== 0) begin errors++; $display("FAIL idle_disabled_frames: got %0d expected 0", fall_cnt); end
    endtask

    task automatic test_single_frame;
        int en_cyc, n0;
        bit ok;
        adc_q.push_back(12'hABC);
        @(negedge clk_sys); #1;
        n0 = vld_cnt; en_cyc = cyc; enable = 1'b1;
        wait_vld_cnt(n0 + 1, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_vld_timeout: got %0d strobes expected %0d", vld_cnt - n0, 1); end
        // trigger is 199 cycles after enable, cs_n falls one cycle later
        checks++; if (fall_cyc - en_cyc !== 200) begin errors++; $display("FAIL single_cs_fall: got %0d expected 200", fall_cyc - en_cyc); end
        // trigger (199) + latency 133
        checks++; if (vld_cyc_q[$] - en_cyc !== 332) begin errors++; $display("FAIL single_latency: got %0d expected 332", vld_cyc_q[$] - en_cyc); end
        checks++; if (vld_dat_q[$] !== exp_data(12'hABC, pat_idx)) begin errors++; $display("FAIL single_data: got %h expected %h", vld_dat_q[$], exp_data(12'hABC, pat_idx)); end
        checks++; if (low_len !== 132) begin errors++; $display("FAIL single_cs_low: got %0d expected 132", low_len); end
        checks++; if (sclk_rises !== 16) begin errors++; $display("FAIL single_sclk_rises: got %0d expected 16", sclk_rises); end
        repeat (20) @(negedge clk_sys);
        #1;
        enable = 1'b0;
        checks++; if (vld_cnt - n0 !== 1) begin errors++; $display("FAIL single_vld_count: got %0d expected 1", vld_cnt - n0); end
        checks++; if (busy_len !== 140) begin errors++; $display("FAIL single_busy_len: got %0d expected 140", busy_len); end
        checks++; if (ad_data !== exp_data(12'hABC, pat_idx)) begin errors++; $display("FAIL single_data_hold: got %h expected %h", ad_data, exp_data(12'hABC, pat_idx)); end
        pat_idx++;
    endtask

    task automatic test_back_to_back;
        int en_cyc, n0, q0;
        bit ok;
        adc_q.push_back(12'h000);
        adc_q.push_back(12'hFFF);
        adc_q.push_back(12'h555);
        @(negedge clk_sys); #1;
        n0 = vld_cnt; q0 = vld_cyc_q.size(); en_cyc = cyc; enable = 1'b1;
        wait_vld_cnt(n0 + 3, 900, ok);
        enable = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL b2b_vld_timeout: got %0d strobes expected 3", vld_cnt - n0); end
        checks++; if (vld_cyc_q[q0] - en_cyc !== 332) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 332", vld_cyc_q[q0] - en_cyc); end
        checks++; if (vld_cyc_q[q0+1] - vld_cyc_q[q0] !== 200) begin errors++; $display("FAIL b2b_gap1: got %0d expected 200", vld_cyc_q[q0+1] - vld_cyc_q[q0]); end
        checks++; if (vld_cyc_q[q0+2] - vld_cyc_q[q0+1] !== 200) begin errors++; $display("FAIL b2b_gap2: got %0d expected 200", vld_cyc_q[q0+2] - vld_cyc_q[q0+1]); end
        checks++; if (vld_dat_q[q0] !== exp_data(12'h000, pat_idx)) begin errors++; $display("FAIL b2b_data0: got %h expected %h", vld_dat_q[q0], exp_data(12'h000, pat_idx)); end
        checks++; if (vld_dat_q[q0+1] !== exp_data(12'hFFF, pat_idx + 1)) begin errors++; $display("FAIL b2b_data1: got %h expected %h", vld_dat_q[q0+1], exp_data(12'hFFF, pat_idx + 1)); end
        checks++; if (vld_dat_q[q0+2] !== exp_data(12'h555, pat_idx + 2)) begin errors++; $display("FAIL b2b_data2: got %h expected %h", vld_dat_q[q0+2], exp_data(12'h555, pat_idx + 2)); end
        checks++; if (ad_miss !== 8'h00) begin errors++; $display("FAIL b2b_miss: got %0d expected 0", ad_miss); end
        pat_idx += 3;
        repeat (20) @(negedge clk_sys);
    endtask

    task automatic test_enable_drop;
        int n0, f0;
        bit ok;
        adc_q.push_back(12'h6C3);
        @(negedge clk_sys); #1;
        n0 = vld_cnt; f0 = fall_cnt; enable = 1'b1;
        wait_fall_cnt(f0 + 1, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL endrop_start_timeout: got %0d frames expected 1", fall_cnt - f0); end
        repeat (50) @(negedge clk_sys);
        #1;
        enable = 1'b0;
        wait_vld_cnt(n0 + 1, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL endrop_vld_timeout: got %0d strobes expected 1", vld_cnt - n0); end
        checks++; if (vld_dat_q[$] !== exp_data(12'h6C3, pat_idx)) begin errors++; $display("FAIL endrop_data: got %h expected %h", vld_dat_q[$], exp_data(12'h6C3, pat_idx)); end
        checks++; if (low_len !== 132) begin errors++; $display("FAIL endrop_cs_low: got %0d expected 132", low_len); end
        repeat (400) @(negedge clk_sys);
        #1;
        checks++; if (fall_cnt - f0 !== 1) begin errors++; $display("FAIL endrop_no_more_frames: got %0d expected 1", fall_cnt - f0); end
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL endrop_cs_idle: got %b expected 1", cs_n); end
        pat_idx++;
    endtask

    task automatic test_miss;
        @(negedge clk_sys); #1;
        enable_f = 1'b1;
        // ten triggers land 99+100k cycles after enable, k=0..9
        repeat (1050) @(negedge clk_sys);
        #1;
        enable_f = 1'b0;
        repeat (10) @(negedge clk_sys);
        #1;
        checks++; if (ad_miss_f !== 8'd5) begin errors++; $display("FAIL miss_count: got %0d expected 5", ad_miss_f); end
        checks++; if (f_vld_cnt !== 5) begin errors++; $display("FAIL miss_vld_count: got %0d expected 5", f_vld_cnt); end
        checks++; if (f_frames !== 5) begin errors++; $display("FAIL miss_frames: got %0d expected 5", f_frames); end
        checks++; if (f_bad_frames !== 0) begin errors++; $display("FAIL miss_truncated: got %0d expected 0", f_bad_frames); end
        checks++; if (ad_miss !== 8'h00) begin errors++; $display("FAIL miss_main_clean: got %0d expected 0", ad_miss); end
    endtask

    task automatic test_reset_mid;
        int n0, f0, rel_cyc;
        bit ok;
        adc_q.push_back(12'h3A5);
        adc_q.push_back(12'h7E1);
        @(negedge clk_sys); #1;
        f0 = fall_cnt; enable = 1'b1;
        wait_fall_cnt(f0 + 1, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_start_timeout: got %0d frames expected 1", fall_cnt - f0); end
        repeat (60) @(negedge clk_sys);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL rstmid_cs_n: got %b expected 1", cs_n); end
        checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL rstmid_sclk: got %b expected 1", sclk); end
        checks++; if (ad_vld !== 1'b0) begin errors++; $display("FAIL rstmid_vld: got %b expected 0", ad_vld); end
        checks++; if (ad_data !== 12'h000) begin errors++; $display("FAIL rstmid_data: got %h expected 000", ad_data); end
        checks++; if (ad_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", ad_busy); end
        checks++; if (ad_miss_f !== 8'h00) begin errors++; $display("FAIL rstmid_miss_clear: got %0d expected 0", ad_miss_f); end
        repeat (2) @(negedge clk_sys);
        #1;
        n0 = vld_cnt; f0 = fall_cnt; rel_cyc = cyc; rst_n = 1'b1;
        wait_vld_cnt(n0 + 1, 400, ok);
        enable = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_vld_timeout: got %0d strobes expected 1", vld_cnt - n0); end
        checks++; if (fall_cyc - rel_cyc !== 200) begin errors++; $display("FAIL rstmid_restart: got %0d expected 200", fall_cyc - rel_cyc); end
        checks++; if (vld_cyc_q[$] - rel_cyc !== 332) begin errors++; $display("FAIL rstmid_latency: got %0d expected 332", vld_cyc_q[$] - rel_cyc); end
        checks++; if (vld_dat_q[$] !== exp_data(12'h7E1, 0)) begin errors++; $display("FAIL rstmid_data_after: got %h expected %h", vld_dat_q[$], exp_data(12'h7E1, 0)); end
        checks++; if (low_len !== 132) begin errors++; $display("FAIL rstmid_cs_low: got %0d expected 132", low_len); end
        checks++; if (sclk_rises !== 16) begin errors++; $display("FAIL rstmid_sclk_rises: got %0d expected 16", sclk_rises); end
        checks++; if (fall_cnt - f0 !== 1) begin errors++; $display("FAIL rstmid_frames: got %0d expected 1", fall_cnt - f0); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_enable_drop();
        test_miss();
        test_reset_mid();
        repeat (5) @(negedge clk_sys);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule : tb_ad_rd
`default_nettype wire

// File: doc/ad_rd.md
# ad_rd

Serial reader for one AD7276-class 12-bit ADC channel; one instance per channel (ch1..ch8) inside `top`, directly behind the `chN_cs_n` / `chN_sclk` / `chN_sdata` pins. It paces conversions from a programmable sample period and runs one 16-clock serial frame per conversion. Each frame yields one 12-bit sample with a single-cycle valid strobe for the downstream processing/UART path. Triggers that arrive while a frame is still in progress are counted as misses.

## Interface
- `CLK_DIV`, 4: SCLK half-period in clk_sys cycles; ≥2.
- `SAMPLE_PERIOD`, 200: clk_sys cycles between conversion triggers.
- `QUIET`, 8: minimum clk_sys cycles cs_n stays high after a frame.
- `clk_sys  in  1`: system clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `enable  in  1`: run conversions while high.
- `sdata  in  1`: ADC serial data, MSB first.
- `cs_n  out  1`: ADC chip select; reset 1.
- `sclk  out  1`: ADC serial clock, idles high; reset 1.
- `ad_data  out  12`: last captured sample; reset 0.
- `ad_vld  out  1`: 1-cycle strobe marking a new `ad_data`; reset 0.
- `ad_busy  out  1`: high from cs_n fall through the end of QUIET; reset 0.
- `ad_miss  out  8`: missed-trigger count, saturates at 255; reset 0.

## Operation
- Trigger counter:
  - Counts 0..SAMPLE_PERIOD-1 while `enable`=1 and issues a trigger at wrap.
  - When `enable`=0: held at 0, no triggers.
- FSM states: S_IDLE, S_SETUP, S_SHIFT, S_QUIET.
- S_IDLE → S_SETUP on trigger.
  - cs_n falls in the cycle after the trigger.
- S_SETUP: cs_n=0, sclk=1 for CLK_DIV cycles, then → S_SHIFT.
- S_SHIFT: 16 SCLK periods.
  - Each period: sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles.
  - `sdata` is sampled into a 16-bit shift register on the clk_sys edge that drives sclk 0→1.
  - After the 16th high phase: cs_n=1, `ad_data`=shift[13:2], `ad_vld`=1 for one cycle; → S_QUIET.
  - shift[15:14] (leading zeros) and shift[1:0] (trailing zeros) are discarded unchecked.
- S_QUIET: QUIET cycles, then → S_IDLE.
- A trigger seen in any state other than S_IDLE:
  - is dropped;
  - increments `ad_miss` (saturating at 255);
  - does not restart or extend the current frame.
- `enable` falling mid-frame: the frame completes normally and `ad_vld` still fires; no further triggers.
- `ad_data` holds its value between strobes.
- `ad_miss` clears only on reset.
- Reset asserted mid-frame: all outputs go to their reset values immediately (cs_n=1, sclk=1); the FSM goes to S_IDLE and counters clear.

## Timing
- Frame length: cs_n fall to cs_n rise = CLK_DIV + 32·CLK_DIV cycles (132 at defaults).
- `ad_vld` is asserted in the same cycle cs_n returns high.
- Latency from trigger to `ad_vld`: 1 + 33·CLK_DIV cycles (133 at defaults).
- Busy window: `ad_busy` covers cs_n-low plus QUIET = 140 cycles at defaults.
- No misses occur when SAMPLE_PERIOD ≥ 1 + 33·CLK_DIV + QUIET; defaults satisfy this.
- sclk and cs_n are driven directly from flops; no combinational output paths.
- Every sdata capture happens at a fixed sclk rising edge. The ADC updates sdata on the falling edge, so it has CLK_DIV cycles to settle.

## Configuration
- `AD_TEST_PATTERN_EN` defined:
  - `ad_data` takes a 12-bit ramp that starts at 0 after reset and increments per frame (wraps 4095→0), not the shifted sdata value.
  - Pin activity and frame timing are unchanged.
- Undefined: `ad_data` comes from sdata as described above.

## Structure
- Shared package `ad_pkg`:
  - FSM state encoding;
  - frame constants: AD_FRAME_BITS=16, AD_DATA_W=12, AD_LEAD_ZEROS=2.
- One natural sub-module, `ad_sclk_gen`:
  - a CLK_DIV phase counter that produces sclk plus one-cycle rise/fall tick strobes;
  - runs only while the FSM is in S_SHIFT.

## Test plan
- Single frame, ADC model returns 0xABC: `enable`=1 → `ad_data`=0xABC with one `ad_vld`, 133 cycles after the trigger; cs_n low for 132 cycles; exactly 16 sclk rising edges.
- Continuous run at defaults with 0x000, 0xFFF, 0x555 in sequence → three strobes 200 cycles apart, values in order, `ad_miss`=0.
- SAMPLE_PERIOD=100 (shorter than the frame) for 10 triggers → every second trigger dropped; `ad_miss`=5; no frame is truncated.
- `enable` dropped 50 cycles into a frame → that frame still completes with `ad_vld`; cs_n stays high afterwards.
- `rst_n` pulsed low 60 cycles into a frame → cs_n=1, sclk=1, `ad_vld`=0, `ad_data`=0 immediately; after release, the next frame starts cleanly 200 cycles later.
- With `AD_TEST_PATTERN_EN` defined: 3 frames → `ad_data` = 0, 1, 2 regardless of sdata.
